tz80_rom_loader: RTL and testbench
==================================

# tz80_rom_loader

ROM download sequencer between the `hps_io` ioctl byte stream and the ROM/PROM stores of the SNK triple-Z80 core. It decodes the stream into per-region write requests and paces `hps_io` with `ioctl_wait`. It also latches the game-select byte and DIP bytes, and holds the core in reset until a complete ROM set has been written. Running checksum, byte count and error flags are kept for OSD and debug.

## Interface
Parameters:
- `NREG`, 8: number of 64 KiB ROM regions; region = `ioctl_addr[24:16]`.
- `RST_HOLD`, 16: cycles `core_rstn` stays low after the last ROM byte drains.

Ports:
- `i_clk`  in  1  core clock, 53.6 MHz.
- `RESETn`  in  1  asynchronous active-low reset.
- `ioctl_download`  in  1  download window from `hps_io`.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_index`  in  8  0 = ROM, 1 = game id, 254 = DIP.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `ioctl_wait`  out  1  backpressure to `hps_io`.
- `rom_valid`  out  1  write request pending.
- `rom_ready`  in  1  target accepts this cycle.
- `rom_sel`  out  NREG  one-hot region select.
- `rom_addr`  out  16  offset in region.
- `rom_data`  out  8  write data.
- `game`  out  8  latched game id.
- `dsw`  out  16  `{dip1, dip0}`.
- `core_rstn`  out  1  core reset, active low.
- `load_done`  out  1  one-cycle pulse when a ROM load completes.
- `byte_count`  out  25  index-0 bytes received this load.
- `sum`  out  16  modulo-2^16 sum of index-0 bytes.
- `err`  out  2  sticky: [0] out-of-range region, [1] overrun.

## Operation
- States: IDLE, LOAD, DRAIN, HOLD, RUN. Reset enters IDLE.
- IDLE/RUN → LOAD when `ioctl_download`=1 and `ioctl_index`=0. Entering LOAD clears `byte_count`, `sum` and `err`.
- LOAD → DRAIN when `ioctl_download` falls.
- DRAIN → HOLD when `rom_valid`=0. The hold counter loads `RST_HOLD-1`.
- HOLD counts down to 0 → RUN. `load_done`=1 on the transition cycle only.
- Downloads with other indices never change state.
- `core_rstn` is registered: 1 only when the state is RUN and `ioctl_download`=0. It drops 1 cycle after any download starts.
- Index-0 write, region < NREG:
  - Loads the buffer: `rom_valid`=1, `rom_sel` = one-hot(region), `rom_addr` = `ioctl_addr[15:0]`, `rom_data` = byte.
  - Adds 1 to `byte_count`; adds the byte to `sum` (wraps at 2^16).
- Index-0 write, region ≥ NREG:
  - Counted and summed, not forwarded; sets `err[0]`.
- Index 1, addr 0: `game` ← byte. Other addresses are ignored.
- Index 254, addr 0/1: `dsw[7:0]` / `dsw[15:8]` ← byte. Other addresses are ignored.
- Buffer holds one entry.
  - `ioctl_wait` = `rom_valid`.
  - Handshake completes when `rom_valid` & `rom_ready`.
  - `rom_sel`/`rom_addr`/`rom_data` are stable while `rom_valid`=1.
- Overrun: an index-0 `ioctl_wr` while `rom_valid`=1 and `rom_ready`=0 is dropped, not counted, and sets `err[1]`.
- A write in the same cycle as a completing handshake is accepted: the buffer refills and `rom_valid` stays 1.
- `ioctl_wr` outside `ioctl_download` is ignored.
- `RESETn` low mid-load: all state cleared and the load is abandoned. A fresh download is required to reach RUN.

## Timing
- Reset values:
  - state IDLE; `core_rstn`=0, `rom_valid`=0, `ioctl_wait`=0.
  - `rom_sel`=0, `rom_addr`=0, `rom_data`=0.
  - `game`=0, `dsw`=16'hFFFF.
  - `load_done`=0, `byte_count`=0, `sum`=0, `err`=0.
- `ioctl_wr` at cycle t → `rom_valid`, outputs and `byte_count`/`sum` updated at t+1.
- Handshake at cycle t with no new write → `rom_valid`=0 at t+1.
- `ioctl_download` falls at t with buffer empty:
  - DRAIN at t+1, HOLD at t+2.
  - RUN and `load_done` at t+2+`RST_HOLD`; `core_rstn`=1 the cycle after.
- `game`/`dsw` update 1 cycle after the strobe.
- All outputs are registered; `ioctl_wait` is a direct copy of registered `rom_valid`.

## Test plan
- Reset, then index-0 download of 4 bytes (addr 0x00000–0x00003, data 01 02 03 04), `rom_ready`=1 → 4 handshakes with `rom_sel`=0x01, `byte_count`=4, `sum`=0x000A; `load_done` pulses once; `core_rstn`=1 `RST_HOLD`+3 cycles after download falls.
- Byte at addr 0x30010 data 0x5A, `rom_ready`=0 for 10 cycles → `rom_sel`=0x08, `rom_addr`=0x0010; `ioctl_wait` high for 10 cycles; outputs stable; one handshake only.
- Second `ioctl_wr` while stalled → byte dropped, `err`=2'b10, `byte_count` unchanged.
- Write to addr 0x90000 with NREG=8 → no `rom_valid`, `err[0]`=1, byte counted and summed.
- Index 1 addr 0 data 0x03, then index 254 bytes 0xC5, 0x7F → `game`=0x03, `dsw`=0x7FC5; state stays RUN; `core_rstn` low only during each download.
- `RESETn` pulsed low mid-load with `rom_valid`=1 → all outputs return to reset values at once; state IDLE; `core_rstn` stays 0 until a full new load.

Source files
------------

// File: rtl/tz80_rom_loader.sv
// ROM download sequencer: turns the hps_io ioctl byte stream into paced
// per-region ROM writes, latches game id / DIP bytes and gates core reset.
module tz80_rom_loader #(
  parameter int NREG     = 8,
  parameter int RST_HOLD = 16
) (
  input  logic            i_clk,
  input  logic            RESETn,
  input  logic            ioctl_download,
  input  logic            ioctl_wr,
  input  logic [7:0]      ioctl_index,
  input  logic [24:0]     ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  output logic            ioctl_wait,
  output logic            rom_valid,
  input  logic            rom_ready,
  output logic [NREG-1:0] rom_sel,
  output logic [15:0]     rom_addr,
  output logic [7:0]      rom_data,
  output logic [7:0]      game,
  output logic [15:0]     dsw,
  output logic            core_rstn,
  output logic            load_done,
  output logic [24:0]     byte_count,
  output logic [15:0]     sum,
  output logic [1:0]      err
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_HOLD,
    S_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            rom_valid_q, rom_valid_d;
  logic [NREG-1:0] rom_sel_q, rom_sel_d;
  logic [15:0]     rom_addr_q, rom_addr_d;
  logic [7:0]      rom_data_q, rom_data_d;
  logic [7:0]      game_q, game_d;
  logic [15:0]     dsw_q, dsw_d;
  logic            core_rstn_q, core_rstn_d;
  logic            load_done_q, load_done_d;
  logic [24:0]     byte_count_q, byte_count_d;
  logic [15:0]     sum_q, sum_d;
  logic [1:0]      err_q, err_d;

  logic            wr_ok;
  logic            wr_rom;
  logic            wr_game;
  logic            wr_dip0;
  logic            wr_dip1;
  logic [8:0]      region;
  logic            in_range;
  logic [NREG-1:0] sel_oh;
  logic            handshake;
  logic            overrun;
  logic            accept;
  logic            start_load;

  assign wr_ok      = ioctl_download & ioctl_wr;
  assign wr_rom     = wr_ok & (ioctl_index == 8'd0);
  assign wr_game    = wr_ok & (ioctl_index == 8'd1)   & (ioctl_addr == 25'd0);
  assign wr_dip0    = wr_ok & (ioctl_index == 8'd254) & (ioctl_addr == 25'd0);
  assign wr_dip1    = wr_ok & (ioctl_index == 8'd254) & (ioctl_addr == 25'd1);
  assign region     = ioctl_addr[24:16];
  assign in_range   = (int'(region) < NREG);
  assign handshake  = rom_valid_q & rom_ready;
  // A byte arriving while the single-entry buffer is stuck has nowhere to go.
  assign overrun    = wr_rom & rom_valid_q & ~rom_ready;
  assign accept     = wr_rom & ~overrun;
  assign start_load = ((state_q == S_IDLE) || (state_q == S_RUN)) &&
                      ioctl_download && (ioctl_index == 8'd0);

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NREG; i++) begin
      sel_oh[i] = (int'(region) == i);
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    load_done_d = 1'b0;
    core_rstn_d = (state_q == S_RUN) && !ioctl_download;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (start_load) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!ioctl_download) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!rom_valid_q) begin
          state_d = S_HOLD;
          hold_d  = HW'(RST_HOLD - 1);
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          state_d     = S_RUN;
          load_done_d = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_valid_d  = rom_valid_q;
    rom_sel_d    = rom_sel_q;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    game_d       = game_q;
    dsw_d        = dsw_q;
    byte_count_d = byte_count_q;
    sum_d        = sum_q;
    err_d        = err_q;

    if (handshake) rom_valid_d = 1'b0;
    // A refill in the handshake cycle overrides the drain above.
    if (accept && in_range) begin
      rom_valid_d = 1'b1;
      rom_sel_d   = sel_oh;
      rom_addr_d  = ioctl_addr[15:0];
      rom_data_d  = ioctl_dout;
    end

    if (start_load) begin
      byte_count_d = '0;
      sum_d        = '0;
      err_d        = '0;
    end
    if (accept) begin
      byte_count_d = byte_count_d + 25'd1;
      sum_d        = sum_d + {8'd0, ioctl_dout};
      if (!in_range) err_d[0] = 1'b1;
    end
    if (overrun) err_d[1] = 1'b1;

    if (wr_game) game_d       = ioctl_dout;
    if (wr_dip0) dsw_d[7:0]   = ioctl_dout;
    if (wr_dip1) dsw_d[15:8]  = ioctl_dout;
  end

  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      rom_valid_q  <= 1'b0;
      rom_sel_q    <= '0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      game_q       <= '0;
      dsw_q        <= 16'hFFFF;
      core_rstn_q  <= 1'b0;
      load_done_q  <= 1'b0;
      byte_count_q <= '0;
      sum_q        <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      rom_valid_q  <= rom_valid_d;
      rom_sel_q    <= rom_sel_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      game_q       <= game_d;
      dsw_q        <= dsw_d;
      core_rstn_q  <= core_rstn_d;
      load_done_q  <= load_done_d;
      byte_count_q <= byte_count_d;
      sum_q        <= sum_d;
      err_q        <= err_d;
    end
  end

  assign ioctl_wait = rom_valid_q;
  assign rom_valid  = rom_valid_q;
  assign rom_sel    = rom_sel_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign game       = game_q;
  assign dsw        = dsw_q;
  assign core_rstn  = core_rstn_q;
  assign load_done  = load_done_q;
  assign byte_count = byte_count_q;
  assign sum        = sum_q;
  assign err        = err_q;

endmodule

// File: tb/tb_tz80_rom_loader.sv
// Bench for tz80_rom_loader: directed scenarios plus a randomized load,
// scored against a transaction-level model of the expected ROM writes.
module tb_tz80_rom_loader;

  localparam int NREG     = 8;
  localparam int RST_HOLD = 16;

  logic        i_clk = 1'b0;
  logic        RESETn = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wait;
  logic        rom_valid;
  logic        rom_ready = 1'b0;
  logic [7:0]  rom_sel;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  game;
  logic [15:0] dsw;
  logic        core_rstn;
  logic        load_done;
  logic [24:0] byte_count;
  logic [15:0] sum;
  logic [1:0]  err;

  always #5 i_clk = ~i_clk;

  tz80_rom_loader #(.NREG(NREG), .RST_HOLD(RST_HOLD)) dut (
    .i_clk(i_clk), .RESETn(RESETn),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .rom_valid(rom_valid), .rom_ready(rom_ready),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .game(game), .dsw(dsw), .core_rstn(core_rstn), .load_done(load_done),
    .byte_count(byte_count), .sum(sum), .err(err)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          push_cnt = 0;
  int          hs_cnt = 0;
  int          ld_cnt = 0;
  logic [24:0] m_cnt = '0;
  logic [15:0] m_sum = '0;
  logic [1:0]  m_err = '0;
  bit          rnd_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_out = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observes the negedge: handshakes against the model queue, stall stability, done pulses.
  task automatic monitor();
    logic [31:0] cur;
    cur = {rom_sel, rom_addr, rom_data};
    if (!RESETn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", 32'(rom_valid), 32'd1);
        check_eq("stall_hold", cur, prev_out);
      end
      if (rom_valid && rom_ready) begin
        hs_cnt++;
        if (exp_q.size() > 0) check_eq("hs_payload", cur, exp_q.pop_front());
      end
      if (load_done) ld_cnt++;
      prev_stall = rom_valid && !rom_ready;
      prev_out   = cur;
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
    if (rnd_en) rom_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic model_rom_byte(input logic [24:0] a, input logic [7:0] d);
    int r;
    logic [7:0] oh;
    r = int'(a[24:16]);
    m_cnt = m_cnt + 25'd1;
    m_sum = m_sum + 16'(d);
    if (r < NREG) begin
      oh = 8'd1 << r;
      exp_q.push_back({oh, a[15:0], d});
      push_cnt++;
    end else begin
      m_err[0] = 1'b1;
    end
  endtask

  task automatic wait_free(input string tag);
    int n;
    n = 0;
    while (ioctl_wait && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check_eq({tag, "_wait_timeout"}, 32'(ioctl_wait), 32'd0);
  endtask

  task automatic send_rom(input logic [24:0] a, input logic [7:0] d);
    wait_free("send");
    ioctl_index = 8'd0;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    model_rom_byte(a, d);
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    if (idx == 8'd0) begin
      m_cnt = '0;
      m_sum = '0;
      m_err = '0;
    end
    tick();
  endtask

  // Ends an index-0 download with the buffer empty and times done/reset release.
  task automatic finish_load(input string tag);
    int ld_k, rs_k, ld0;
    wait_free(tag);
    ld0 = ld_cnt;
    ld_k = 0;
    rs_k = 0;
    ioctl_download = 1'b0;
    for (int k = 1; k <= RST_HOLD + 20; k++) begin
      tick();
      if (load_done && ld_k == 0) ld_k = k;
      if (core_rstn && rs_k == 0) rs_k = k;
    end
    check_eq({tag, "_done_cycle"}, 32'(ld_k), 32'(RST_HOLD + 2));
    check_eq({tag, "_rstn_cycle"}, 32'(rs_k), 32'(RST_HOLD + 3));
    check_eq({tag, "_done_pulses"}, 32'(ld_cnt - ld0), 32'd1);
  endtask

  initial begin
    int hs0, ld0, wh, rs_hi;
    logic [8:0]  r9;
    logic [15:0] off;

    // Reset values
    repeat (3) tick();
    check_eq("rst_core_rstn", 32'(core_rstn), 32'd0);
    check_eq("rst_valid", 32'(rom_valid), 32'd0);
    check_eq("rst_wait", 32'(ioctl_wait), 32'd0);
    check_eq("rst_out", {rom_sel, rom_addr, rom_data}, 32'd0);
    check_eq("rst_game", 32'(game), 32'd0);
    check_eq("rst_dsw", 32'(dsw), 32'hFFFF);
    check_eq("rst_done", 32'(load_done), 32'd0);
    check_eq("rst_count", 32'(byte_count), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    RESETn = 1'b1;
    tick();

    // Basic 4-byte load into region 0
    hs0 = hs_cnt;
    start_dl(8'd0);
    rom_ready = 1'b1;
    send_rom(25'h00000, 8'h01);
    check_eq("t1_first_valid", 32'(rom_valid), 32'd1);
    check_eq("t1_first_out", {rom_sel, rom_addr, rom_data}, 32'h01_0000_01);
    send_rom(25'h00001, 8'h02);
    send_rom(25'h00002, 8'h03);
    send_rom(25'h00003, 8'h04);
    finish_load("t1");
    check_eq("t1_hs", 32'(hs_cnt - hs0), 32'd4);
    check_eq("t1_count", 32'(byte_count), 32'd4);
    check_eq("t1_sum", 32'(sum), 32'h000A);

    // Stalled write, overrun, out-of-range region
    start_dl(8'd0);
    check_eq("t2_rstn_drop", 32'(core_rstn), 32'd0);
    rom_ready = 1'b0;
    hs0 = hs_cnt;
    send_rom(25'h30010, 8'h5A);
    check_eq("t2_valid", 32'(rom_valid), 32'd1);
    check_eq("t2_out", {rom_sel, rom_addr, rom_data}, 32'h08_0010_5A);
    check_eq("t2_count", 32'(byte_count), 32'd1);
    wh = 0;
    for (int i = 0; i < 10; i++) begin
      if (ioctl_wait) wh++;
      if (i == 4) begin
        ioctl_addr = 25'h30011;
        ioctl_dout = 8'h77;
        ioctl_wr   = 1'b1;
        m_err[1]   = 1'b1;
      end
      tick();
      ioctl_wr = 1'b0;
    end
    check_eq("t2_wait_cycles", 32'(wh), 32'd10);
    check_eq("t3_err", 32'(err), 32'(m_err));
    check_eq("t3_err_lit", 32'(err), 32'd2);
    check_eq("t3_count", 32'(byte_count), 32'd1);
    rom_ready = 1'b1;
    tick();
    check_eq("t2_drained", 32'(rom_valid), 32'd0);
    check_eq("t2_hs", 32'(hs_cnt - hs0), 32'd1);
    send_rom(25'h90000, 8'h11);
    check_eq("t4_no_valid", 32'(rom_valid), 32'd0);
    check_eq("t4_err", 32'(err), 32'd3);
    check_eq("t4_count", 32'(byte_count), 32'd2);
    check_eq("t4_sum", 32'(sum), 32'h006B);
    finish_load("t4");

    // Game id and DIP bytes while running
    ld0 = ld_cnt;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick();
    check_eq("t5_rstn_low_game", 32'(core_rstn), 32'd0);
    strobe(8'd1, 25'd0, 8'h03);
    check_eq("t5_game", 32'(game), 32'h03);
    strobe(8'd1, 25'd1, 8'h55);
    check_eq("t5_game_ignore", 32'(game), 32'h03);
    ioctl_download = 1'b0;
    tick();
    check_eq("t5_rstn_back", 32'(core_rstn), 32'd1);
    ioctl_index = 8'd254;
    ioctl_download = 1'b1;
    tick();
    check_eq("t5_rstn_low_dip", 32'(core_rstn), 32'd0);
    strobe(8'd254, 25'd0, 8'hC5);
    strobe(8'd254, 25'd1, 8'h7F);
    strobe(8'd254, 25'd2, 8'h00);
    check_eq("t5_dsw", 32'(dsw), 32'h7FC5);
    ioctl_download = 1'b0;
    tick();
    check_eq("t5_rstn_run", 32'(core_rstn), 32'd1);
    strobe(8'd0, 25'h00005, 8'h99);
    check_eq("t5_nodl_valid", 32'(rom_valid), 32'd0);
    check_eq("t5_nodl_count", 32'(byte_count), 32'd2);
    check_eq("t5_no_done", 32'(ld_cnt - ld0), 32'd0);

    // Randomized load with random target backpressure
    start_dl(8'd0);
    rnd_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      r9  = 9'($urandom_range(0, NREG + 1));
      off = 16'($urandom_range(0, 65535));
      send_rom({r9, off}, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) tick();
    end
    finish_load("rnd");
    rnd_en = 1'b0;
    rom_ready = 1'b1;
    check_eq("rnd_count", 32'(byte_count), 32'(m_cnt));
    check_eq("rnd_sum", 32'(sum), 32'(m_sum));
    check_eq("rnd_err", 32'(err), 32'(m_err));
    check_eq("rnd_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-load
    start_dl(8'd0);
    rom_ready = 1'b0;
    send_rom(25'h10020, 8'hAB);
    check_eq("t6_valid_before", 32'(rom_valid), 32'd1);
    #2;
    RESETn = 1'b0;
    #1;
    check_eq("t6_valid", 32'(rom_valid), 32'd0);
    check_eq("t6_wait", 32'(ioctl_wait), 32'd0);
    check_eq("t6_out", {rom_sel, rom_addr, rom_data}, 32'd0);
    check_eq("t6_count", 32'(byte_count), 32'd0);
    check_eq("t6_sum", 32'(sum), 32'd0);
    check_eq("t6_err", 32'(err), 32'd0);
    check_eq("t6_game", 32'(game), 32'd0);
    check_eq("t6_dsw", 32'(dsw), 32'hFFFF);
    check_eq("t6_rstn", 32'(core_rstn), 32'd0);
    push_cnt -= exp_q.size();
    exp_q.delete();
    ioctl_download = 1'b0;
    repeat (3) tick();
    RESETn = 1'b1;
    ld0 = ld_cnt;
    rs_hi = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (core_rstn) rs_hi++;
    end
    check_eq("t6_rstn_held", 32'(rs_hi), 32'd0);
    check_eq("t6_no_done", 32'(ld_cnt - ld0), 32'd0);
    start_dl(8'd0);
    rom_ready = 1'b1;
    send_rom(25'h20000, 8'h10);
    send_rom(25'h2FFFF, 8'h20);
    finish_load("t6_reload");
    check_eq("t6_reload_count", 32'(byte_count), 32'd2);
    check_eq("t6_reload_sum", 32'(sum), 32'h0030);

    check_eq("hs_total", 32'(hs_cnt), 32'(push_cnt));
    check_eq("q_final_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
